// File: rtl/redas_dataflow_controller_pkg.sv
// Shared types and crossbar configuration constants for the ReDAS dataflow controller.
// The configuration struct packs the three broadcast PE fields into one register.
package redas_ctrl_pkg;

  typedef enum logic [1:0] {
    DF_WS   = 2'd0,
    DF_OS   = 2'd1,
    DF_IS   = 2'd2,
    DF_RSVD = 2'd3
  } dataflow_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_PRELOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  typedef struct packed {
    logic [3:0] dm;
    logic [4:0] cp;
    logic       rama;
  } redas_cfg_t;

  localparam redas_cfg_t CFG_BYPASS = '{dm: 4'b1111, cp: 5'b11000, rama: 1'b1};
  localparam redas_cfg_t CFG_WS     = '{dm: 4'b1111, cp: 5'b00111, rama: 1'b1};
  localparam redas_cfg_t CFG_OS     = '{dm: 4'b1111, cp: 5'b00101, rama: 1'b1};
  localparam redas_cfg_t CFG_IS     = '{dm: 4'b1111, cp: 5'b00110, rama: 1'b0};
  // Drain reuses the pass-through pattern so accumulators shift out row by row.
  localparam redas_cfg_t CFG_DRAIN  = '{dm: 4'b1111, cp: 5'b11000, rama: 1'b1};

  function automatic dataflow_e resolve_df(input logic [1:0] sel);
    dataflow_e df;
    df = dataflow_e'(sel);
    if (df == DF_RSVD) begin
      df = DF_WS;
    end
    return df;
  endfunction

  function automatic redas_cfg_t cfg_for(input dataflow_e df);
    redas_cfg_t cfg;
    case (df)
      DF_OS:   cfg = CFG_OS;
      DF_IS:   cfg = CFG_IS;
      default: cfg = CFG_WS;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/redas_dataflow_controller_if.sv
// Scheduler/feeder-facing bundle of the ReDAS dataflow controller.
// The master side drives tile requests and operand readiness; the slave is the controller.
interface redas_dataflow_controller_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8
);

  localparam int RowW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic               start;
  logic [1:0]         dataflow_sel;
  logic [K_WIDTH-1:0] k_len;
  logic               stream_ready;
  logic [3:0]         data_movement_mode;
  logic [4:0]         calculation_pattern_mode;
  logic               enable_right_angle_movement;
  logic               preload_en;
  logic [RowW-1:0]    preload_row;
  logic               stream_valid;
  logic               drain_valid;
  logic               busy;
  logic               done;
  logic               cfg_error;

  modport master (
    output start, dataflow_sel, k_len, stream_ready,
    input  data_movement_mode, calculation_pattern_mode, enable_right_angle_movement,
    input  preload_en, preload_row, stream_valid, drain_valid, busy, done, cfg_error
  );

  modport slave (
    input  start, dataflow_sel, k_len, stream_ready,
    output data_movement_mode, calculation_pattern_mode, enable_right_angle_movement,
    output preload_en, preload_row, stream_valid, drain_valid, busy, done, cfg_error
  );

endinterface

// File: rtl/redas_dataflow_controller_phase_counter.sv
// Loadable down-counter shared by the preload, stream and drain phases.
// Load value is (phase length - 1); last_o flags the final cycle of the phase.
module redas_phase_counter #(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 last_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Load wins over enable so a phase hand-off never loses its first cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/redas_dataflow_controller.sv
// Tile sequencer for the ReDAS roundabout systolic array: picks a dataflow, broadcasts
// the PE crossbar configuration and walks the array through preload, stream and drain.
module redas_dataflow_controller
  import redas_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  redas_dataflow_controller_if.slave ctrl_if
);

  localparam int RowW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int CntW = K_WIDTH + 1 + $clog2(2 * ARRAY_SIZE);

  generate
    if (ARRAY_SIZE < 2 || DATA_WIDTH < 1) begin : g_param_check
      $error("redas_dataflow_controller: ARRAY_SIZE must be >= 2 and DATA_WIDTH >= 1");
    end
  endgenerate

  ctrl_state_e        state_q;
  redas_cfg_t         cfg_q;
  logic               preload_en_q;
  logic [RowW-1:0]    preload_row_q;
  logic               stream_phase_q;
  logic               drain_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               cfg_error_q;
  dataflow_e          df_q;
  logic [K_WIDTH-1:0] k_q;

  logic            cnt_load;
  logic            cnt_en;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_last;
  logic [CntW-1:0] preload_len;
  logic [CntW-1:0] stream_len;

  // Stream covers k operands plus 2*(N-1) skew fill/flush beats; guard bits stop k=max wrapping.
  assign preload_len = CntW'(ARRAY_SIZE - 1);
  assign stream_len  = CntW'(k_q) + CntW'(2 * ARRAY_SIZE - 3);

  always_comb begin
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = preload_len;
    case (state_q)
      ST_CONFIG: begin
        cnt_load     = 1'b1;
        cnt_load_val = (df_q == DF_OS) ? stream_len : preload_len;
      end
      ST_PRELOAD: begin
        if (cnt_last) begin
          cnt_load     = 1'b1;
          cnt_load_val = stream_len;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_STREAM: begin
        if (ctrl_if.stream_ready) begin
          if (cnt_last) begin
            cnt_load     = (df_q == DF_OS);
            cnt_load_val = preload_len;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DRAIN: cnt_en = 1'b1;
      default: ;
    endcase
  end

  redas_phase_counter #(
    .CNT_WIDTH (CntW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_load_val),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && ctrl_if.start) begin
      df_q <= resolve_df(ctrl_if.dataflow_sel);
      k_q  <= ctrl_if.k_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cfg_q          <= CFG_BYPASS;
      preload_en_q   <= 1'b0;
      preload_row_q  <= '0;
      stream_phase_q <= 1'b0;
      drain_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_error_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_if.start) begin
            state_q     <= ST_CONFIG;
            busy_q      <= 1'b1;
            cfg_q       <= cfg_for(resolve_df(ctrl_if.dataflow_sel));
            cfg_error_q <= (ctrl_if.dataflow_sel == DF_RSVD);
          end
        end
        ST_CONFIG: begin
          if (k_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            cfg_q   <= CFG_BYPASS;
          end else if (df_q == DF_OS) begin
            state_q        <= ST_STREAM;
            stream_phase_q <= 1'b1;
          end else begin
            state_q       <= ST_PRELOAD;
            preload_en_q  <= 1'b1;
            preload_row_q <= '0;
          end
        end
        ST_PRELOAD: begin
          if (cnt_last) begin
            state_q        <= ST_STREAM;
            preload_en_q   <= 1'b0;
            preload_row_q  <= '0;
            stream_phase_q <= 1'b1;
          end else begin
            preload_row_q <= preload_row_q + RowW'(1);
          end
        end
        ST_STREAM: begin
          // A stall (stream_ready low) holds both state and beat counter.
          if (ctrl_if.stream_ready && cnt_last) begin
            stream_phase_q <= 1'b0;
            if (df_q == DF_OS) begin
              state_q       <= ST_DRAIN;
              drain_valid_q <= 1'b1;
              cfg_q         <= CFG_DRAIN;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              cfg_q   <= CFG_BYPASS;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_last) begin
            state_q       <= ST_DONE;
            drain_valid_q <= 1'b0;
            done_q        <= 1'b1;
            cfg_q         <= CFG_BYPASS;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_if.data_movement_mode          = cfg_q.dm;
  assign ctrl_if.calculation_pattern_mode    = cfg_q.cp;
  assign ctrl_if.enable_right_angle_movement = cfg_q.rama;
  assign ctrl_if.preload_en                  = preload_en_q;
  assign ctrl_if.preload_row                 = preload_row_q;
  assign ctrl_if.stream_valid                = stream_phase_q & ctrl_if.stream_ready;
  assign ctrl_if.drain_valid                 = drain_valid_q;
  assign ctrl_if.busy                        = busy_q;
  assign ctrl_if.done                        = done_q;
  assign ctrl_if.cfg_error                   = cfg_error_q;

endmodule

// File: tb/tb_redas_dataflow_controller.sv
// Scoreboard bench for redas_dataflow_controller: each launched tile pushes its expected
// latency and phase lengths; the negedge monitor pops and compares when done pulses.
module tb_redas_dataflow_controller;

  localparam int A  = 4;
  localparam int KW = 8;
  localparam logic [9:0]  BYP     = {4'b1111, 5'b11000, 1'b1};
  localparam logic [17:0] RST_IMG = {BYP, 8'b0};

  typedef struct {
    int         t0;
    int         lat;
    int         n_pre;
    int         n_str;
    int         n_dr;
    logic [4:0] cp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  redas_dataflow_controller_if #(.ARRAY_SIZE(A), .K_WIDTH(KW)) bus ();

  redas_dataflow_controller #(
    .DATA_WIDTH (8),
    .ARRAY_SIZE (A),
    .K_WIDTH    (KW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tiles_done = 0;
  int   pre_n = 0;
  int   str_n = 0;
  int   dr_n = 0;
  bit   rdy_toggle = 1'b0;
  int   rdy_base = 0;

  logic [9:0]  cfg_obs;
  logic [17:0] img_obs;
  assign cfg_obs = {bus.data_movement_mode, bus.calculation_pattern_mode,
                    bus.enable_right_angle_movement};
  assign img_obs = {cfg_obs, bus.preload_en, bus.preload_row, bus.stream_valid,
                    bus.drain_valid, bus.busy, bus.done, bus.cfg_error};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] exp_cfg(input logic [1:0] sel);
    case (sel)
      2'd1:    return {4'b1111, 5'b00101, 1'b1};
      2'd2:    return {4'b1111, 5'b00110, 1'b0};
      default: return {4'b1111, 5'b00111, 1'b1};
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Feeder model: either always ready, or ready on every other cycle from stream start.
  always @(posedge clk) begin
    #1;
    bus.stream_ready = rdy_toggle ? (((cyc - rdy_base) % 2) == 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pre_n = 0;
      str_n = 0;
      dr_n  = 0;
    end else begin
      if (bus.preload_en) begin
        chk_eq("preload_row", 32'(bus.preload_row), 32'(pre_n));
        pre_n++;
      end
      if (bus.stream_valid) begin
        str_n++;
        if (exp_q.size() > 0)
          chk_eq("stream_cp", 32'(bus.calculation_pattern_mode), 32'(exp_q[0].cp));
      end
      if (bus.drain_valid) begin
        dr_n++;
        chk_eq("drain_cp", 32'(bus.calculation_pattern_mode), 32'(5'b11000));
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("done_latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
          chk_eq("preload_count", 32'(pre_n), 32'(mon_e.n_pre));
          chk_eq("stream_count", 32'(str_n), 32'(mon_e.n_str));
          chk_eq("drain_count", 32'(dr_n), 32'(mon_e.n_dr));
          chk_eq("done_cfg_bypass", 32'(cfg_obs), 32'(BYP));
        end
        pre_n = 0;
        str_n = 0;
        dr_n  = 0;
        tiles_done++;
      end
    end
  end

  task automatic launch(input logic [1:0] sel, input int k, input bit toggle);
    exp_t       e;
    int         str;
    logic [9:0] c;
    @(posedge clk);
    #1;
    c       = exp_cfg(sel);
    str     = (k == 0) ? 0 : k + 2 * A - 2;
    e.t0    = cyc;
    e.n_str = str;
    e.cp    = c[5:1];
    if (k == 0) begin
      e.n_pre = 0; e.n_dr = 0; e.lat = 2;
    end else if (sel == 2'd1) begin
      e.n_pre = 0; e.n_dr = A; e.lat = 2 + str + A;
    end else begin
      e.n_pre = A; e.n_dr = 0; e.lat = 2 + A + str;
    end
    if (toggle && str > 0) e.lat += str - 1;
    rdy_toggle = toggle;
    rdy_base   = cyc + ((sel == 2'd1) ? 2 : 2 + A);
    exp_q.push_back(e);
    bus.start        = 1'b1;
    bus.dataflow_sel = sel;
    bus.k_len        = KW'(k);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk_eq("config_busy", 32'(bus.busy), 32'd1);
    chk_eq("config_vector", 32'(cfg_obs), 32'(c));
    chk_eq("config_cfg_error", 32'(bus.cfg_error), 32'(sel == 2'd3));
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (tiles_done == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk_eq("done_seen", 32'(tiles_done > base), 32'd1);
    @(negedge clk);
    chk_eq("idle_after_done", 32'({bus.busy, bus.done}), 32'd0);
  endtask

  task automatic run_tile(input logic [1:0] sel, input int k, input bit toggle);
    int b;
    b = tiles_done;
    launch(sel, k, toggle);
    wait_done(b);
  endtask

  initial begin
    int b;
    int n;
    bus.start        = 1'b0;
    bus.dataflow_sel = 2'd0;
    bus.k_len        = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("reset_image", 32'(img_obs), 32'(RST_IMG));
    end

    run_tile(2'd0, 3, 1'b0);
    run_tile(2'd1, 3, 1'b1);
    run_tile(2'd2, 0, 1'b0);
    run_tile(2'd3, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("cfg_error_sticky", 32'(bus.cfg_error), 32'd1);
    run_tile(2'd0, 2, 1'b0);
    run_tile(2'd2, 2, 1'b0);
    run_tile(2'd1, 1, 1'b0);

    // Extra start during STREAM, then reset mid-tile.
    b = tiles_done;
    launch(2'd0, 6, 1'b0);
    n = 0;
    while (!bus.stream_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("reached_stream", 32'(bus.stream_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.start        = 1'b1;
    bus.dataflow_sel = 2'd1;
    bus.k_len        = KW'(1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk_eq("ignored_start", 32'({bus.busy, bus.calculation_pattern_mode}), 32'({1'b1, 5'b00111}));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("reset_mid_tile", 32'(img_obs), 32'(RST_IMG));
    repeat (30) @(negedge clk);
    chk_eq("no_done_after_rst", 32'(tiles_done), 32'(b));
    chk_eq("idle_after_rst", 32'(bus.busy), 32'd0);

    run_tile(2'd0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/redas_dataflow_controller.md
# redas_dataflow_controller

Sequencer for an ARRAY_SIZE x ARRAY_SIZE grid of ReDAS reconfigurable PEs in a roundabout systolic array. Per tile, it selects a dataflow (weight-, output- or input-stationary) and drives the shared per-PE crossbar configuration (`data_movement_mode`, `calculation_pattern_mode`, `enable_right_angle_movement`). It then walks the array through preload, stream and drain phases, with a valid/ready handshake toward the operand feeder. It sits between the tile scheduler and the PE array.

## Interface
Parameters:
- `DATA_WIDTH`, 8: PE operand width; carried for package consistency only.
- `ARRAY_SIZE`, 4: PE rows = PE columns; minimum 2.
- `K_WIDTH`, 8: width of the reduction-length field.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: tile request; sampled only in IDLE.
- `dataflow_sel`  in  2: 0 = WS, 1 = OS, 2 = IS, 3 = reserved (treated as WS, sets `cfg_error`).
- `k_len`  in  K_WIDTH: reduction length; sampled with `start`.
- `stream_ready`  in  1: feeder has operands this cycle.
- `data_movement_mode`  out  4: broadcast to all PEs.
- `calculation_pattern_mode`  out  5: broadcast to all PEs.
- `enable_right_angle_movement`  out  1: broadcast to all PEs.
- `preload_en`  out  1: stationary operand write strobe.
- `preload_row`  out  $clog2(ARRAY_SIZE): row being preloaded.
- `stream_valid`  out  1: array advances with fed operands this cycle.
- `drain_valid`  out  1: result row on array edge is valid.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at tile completion.
- `cfg_error`  out  1: sticky; cleared by the next accepted `start`.

## Operation
- FSM states: IDLE, CONFIG, PRELOAD, STREAM, DRAIN, DONE.
- IDLE:
  - Config outputs hold BYPASS: dm = 4'b1111, cp = 5'b11000, rama = 1.
  - `start` = 1 latches `dataflow_sel` and `k_len`, then goes to CONFIG.
- `start` outside IDLE is ignored; no queueing.
- CONFIG (1 cycle) drives the per-dataflow configuration, held until DONE:
  - WS: dm 4'b1111, cp 5'b00111, rama 1.
  - OS: dm 4'b1111, cp 5'b00101, rama 1.
  - IS: dm 4'b1111, cp 5'b00110, rama 0.
- CONFIG next state:
  - `k_len` = 0: DONE (no preload, no stream).
  - OS: STREAM.
  - Otherwise: PRELOAD.
- PRELOAD: exactly ARRAY_SIZE cycles.
  - `preload_en` = 1.
  - `preload_row` counts 0..ARRAY_SIZE-1.
  - Not gated by `stream_ready`.
- STREAM: beat counter runs 0..k_len+2*ARRAY_SIZE-3, covering k_len operands plus skew fill/flush.
  - `stream_valid` = `stream_ready`; the counter advances only when `stream_ready` = 1.
  - A stall freezes the counter and state.
  - After the last counted beat: OS goes to DRAIN, WS/IS go to DONE.
- DRAIN (OS only): ARRAY_SIZE cycles, `drain_valid` = 1.
  - Config switches to cp 5'b11000 so the accumulators shift out through the pass-through registers.
  - Not gated by `stream_ready`.
- DONE (1 cycle): `done` = 1, config returns to BYPASS, then IDLE.
- Reserved `dataflow_sel`: sets `cfg_error` and runs as WS.
- Width arithmetic: the stream limit is computed in K_WIDTH+1 bits (plus $clog2(2*ARRAY_SIZE) guard bits), so `k_len` = max does not wrap.

## Timing
- Every output is a register; nothing is combinational from inputs to outputs except `stream_valid`, which is the registered phase flag AND `stream_ready`.
- Reset values:
  - State IDLE, all counters 0.
  - dm 4'b1111, cp 5'b11000, rama 1.
  - `preload_en`, `stream_valid`, `drain_valid`, `busy`, `done`, `cfg_error` all 0; `preload_row` 0.
- `start` at cycle t: `busy` rises at t+1 (CONFIG); the per-dataflow configuration is visible at t+1.
- Unstalled total latency, `start` to `done` high:
  - WS/IS: 2 + ARRAY_SIZE + (k_len + 2*ARRAY_SIZE - 2) cycles.
  - OS: 2 + (k_len + 2*ARRAY_SIZE - 2) + ARRAY_SIZE cycles.
- Each stall cycle adds exactly one cycle.
- `rst` mid-tile: next edge forces the full reset image; any partial tile is discarded and no `done` is produced.

## Structure
- Package `redas_ctrl_pkg`:
  - `dataflow_e` enum.
  - `redas_cfg_t` struct: dm[3:0], cp[4:0], rama.
  - Constants `CFG_BYPASS`, `CFG_WS`, `CFG_OS`, `CFG_IS`, `CFG_DRAIN`.
- Sub-module `redas_phase_counter`:
  - Loadable down-counter with enable and `last` flag.
  - Reused for the PRELOAD, STREAM and DRAIN lengths.

## Test plan
- Reset, then idle 5 cycles -> outputs equal the reset image; `busy` = 0; no `done`.
- WS, ARRAY_SIZE = 4, k_len = 3, `stream_ready` tied 1:
  - `preload_row` 0,1,2,3.
  - 9 `stream_valid` cycles.
  - `done` at start+15.
  - cp = 5'b00111 throughout the tile.
- OS, k_len = 3, ready toggling 1010…:
  - 9 counted beats; the 8 stall cycles (`stream_valid` = 0) hold state and counter.
  - Then 4 `drain_valid` cycles with cp = 5'b11000.
  - `done` at start+23.
- IS, k_len = 0 -> CONFIG then DONE: `done` at start+2; no `preload_en`, no `stream_valid`; rama = 0 during CONFIG only.
- `dataflow_sel` = 3 with k_len = 1 -> WS timing; `cfg_error` = 1 until the next accepted `start`.
- `start` pulsed in mid-STREAM, then `rst` asserted mid-STREAM:
  - The extra `start` is ignored.
  - `rst` yields the reset image next cycle; `done` never pulses.
